// File: rtl/alu_m_execute_unit_if.sv
// Dispatch, flush and CDB handshake bundle for the RV32M execute unit.
// master = reservation station / CDB side, slave = execute unit.
interface alu_m_execute_unit_if #(
  parameter int ROBSIZE = 8
);
  logic               i_flush;
  logic               i_alu_ex_en;
  logic [2:0]         i_alu_opcode;
  logic [31:0]        i_rs1_value;
  logic [31:0]        i_rs2_value;
  logic [ROBSIZE-1:0] i_rob_addr;
  logic               o_alu_busy;
  logic               o_cdb_req;
  logic               i_cdb_gnt;
  logic [ROBSIZE-1:0] o_cdb_rob_addr;
  logic [31:0]        o_cdb_data;

  modport master (
    output i_flush, i_alu_ex_en, i_alu_opcode,
    output i_rs1_value, i_rs2_value, i_rob_addr,
    output i_cdb_gnt,
    input  o_alu_busy, o_cdb_req,
    input  o_cdb_rob_addr, o_cdb_data
  );

  modport slave (
    input  i_flush, i_alu_ex_en, i_alu_opcode,
    input  i_rs1_value, i_rs2_value, i_rob_addr,
    input  i_cdb_gnt,
    output o_alu_busy, o_cdb_req,
    output o_cdb_rob_addr, o_cdb_data
  );
endinterface

// File: rtl/alu_m_execute_unit.sv
// RV32M execute unit: iterative shift-add multiply, restoring divide.
// Define ALU_M_FAST_MUL_EN for a single-cycle 33x33 signed multiplier.
module alu_m_execute_unit #(
  parameter int ROBSIZE = 8
) (
  input logic               clk,
  input logic               rstn,
  alu_m_execute_unit_if.slave bus
);

`ifdef ALU_M_FAST_MUL_EN
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [31:0]        data_q, data_d;
  logic [ROBSIZE-1:0] tag_q, tag_d;

  logic        is_div;
  logic        sgn1, sgn2;
  logic [31:0] mag1, mag2;
  logic        div_zero, div_ovf;
  logic [32:0] diff;
  logic [63:0] dstep;
  logic [31:0] quo, rem;

  // operand signedness, magnitudes and special-case detection
  always_comb begin
    is_div = bus.i_alu_opcode[2];
    if (is_div) begin
      sgn1 = bus.i_rs1_value[31] & ~bus.i_alu_opcode[0];
      sgn2 = bus.i_rs2_value[31] & ~bus.i_alu_opcode[0];
    end else begin
      sgn1 = bus.i_rs1_value[31] & (bus.i_alu_opcode[1:0] != 2'b11);
      sgn2 = bus.i_rs2_value[31] & ~bus.i_alu_opcode[1];
    end
    mag1 = sgn1 ? -bus.i_rs1_value : bus.i_rs1_value;
    mag2 = sgn2 ? -bus.i_rs2_value : bus.i_rs2_value;
    div_zero = (bus.i_rs2_value == 32'h0);
    div_ovf  = ~bus.i_alu_opcode[0]
             & (bus.i_rs1_value == 32'h8000_0000)
             & (bus.i_rs2_value == 32'hFFFF_FFFF);
  end

  // one restoring-division step on acc = {rem, quo}
  always_comb begin
    diff = {acc_q[63:32], acc_q[31]} - {1'b0, opb_q};
    if (!diff[32]) dstep = {diff[31:0], acc_q[30:0], 1'b1};
    else           dstep = {acc_q[62:0], 1'b0};
    rem = rneg_q ? -dstep[63:32] : dstep[63:32];
    quo = neg_q  ? -dstep[31:0]  : dstep[31:0];
  end

`ifdef ALU_M_FAST_MUL_EN
  logic signed [32:0] fa, fb;
  logic signed [65:0] fprod;
  logic               unused_fast;

  // single-cycle signed multiply on sign/zero-extended operands
  always_comb begin
    fa = {sgn1, bus.i_rs1_value};
    fb = {sgn2, bus.i_rs2_value};
    fprod = fa * fb;
    unused_fast = ^{fprod[65:64], op_q[0]};
  end
`else
  logic [32:0] sum;
  logic [63:0] mstep;
  logic [63:0] prod;

  // one shift-add step on acc = {partial, multiplier}
  always_comb begin
    sum = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
    if (acc_q[0]) mstep = {sum, acc_q[31:1]};
    else          mstep = {1'b0, acc_q[63:1]};
    prod = neg_q ? -mstep : mstep;
  end
`endif

  // next-state and datapath update, flush wins over everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_alu_ex_en) begin
            op_d   = bus.i_alu_opcode[1:0];
            tag_d  = bus.i_rob_addr;
            cnt_d  = 5'd0;
            neg_d  = sgn1 ^ sgn2;
            rneg_d = sgn1;
            if (is_div) begin
              if (div_zero) begin
                data_d  = bus.i_alu_opcode[1] ? bus.i_rs1_value : 32'hFFFF_FFFF;
                state_d = DONE;
              end else if (div_ovf) begin
                data_d  = bus.i_alu_opcode[1] ? 32'h0 : 32'h8000_0000;
                state_d = DONE;
              end else begin
                acc_d   = {32'h0, mag1};
                opb_d   = mag2;
                state_d = DIV;
              end
            end else begin
`ifdef ALU_M_FAST_MUL_EN
              data_d  = (bus.i_alu_opcode[1:0] == 2'b00) ? fprod[31:0] : fprod[63:32];
              state_d = DONE;
`else
              acc_d   = {32'h0, mag2};
              opb_d   = mag1;
              state_d = MUL;
`endif
            end
          end
        end
`ifndef ALU_M_FAST_MUL_EN
        MUL: begin
          acc_d = mstep;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            data_d  = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
            state_d = DONE;
          end
        end
`endif
        DIV: begin
          acc_d = dstep;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            data_d  = op_q[1] ? rem : quo;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.i_cdb_gnt) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.o_alu_busy     = (state_q != IDLE);
  assign bus.o_cdb_req      = (state_q == DONE);
  assign bus.o_cdb_data     = data_q;
  assign bus.o_cdb_rob_addr = tag_q;

endmodule

// File: tb/tb_alu_m_execute_unit.sv
// Scoreboard bench for alu_m_execute_unit: directed RV32M vectors,
// flush and reset abort, CDB hold and dispatch-acceptance checks.
module tb_alu_m_execute_unit;

  localparam int RS = 8;

`ifdef ALU_M_FAST_MUL_EN
  localparam int MLAT = 0;
`else
  localparam int MLAT = 32;
`endif

  typedef struct {
    logic [RS-1:0] tag;
    logic [31:0]   data;
    int            e0;
    int            off;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  bit   req_seen = 1'b0;

  alu_m_execute_unit_if #(.ROBSIZE(RS)) bus ();

  alu_m_execute_unit #(.ROBSIZE(RS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // monitor: compare each new CDB request against the scoreboard head
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.o_cdb_req === 1'b1 && !req_seen) begin
      req_seen = 1'b1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req actual=tag %h data %h expected=none",
                 bus.o_cdb_rob_addr, bus.o_cdb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cdb_data", bus.o_cdb_data, e.data);
        chk("cdb_tag", 32'(bus.o_cdb_rob_addr), 32'(e.tag));
        chk("latency", 32'(cyc - e.e0), 32'(e.off));
      end
    end
    if (bus.o_cdb_req !== 1'b1) req_seen = 1'b0;
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [RS-1:0] tag);
    bus.i_alu_ex_en  = 1'b1;
    bus.i_alu_opcode = op;
    bus.i_rs1_value  = a;
    bus.i_rs2_value  = b;
    bus.i_rob_addr   = tag;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (bus.o_cdb_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_cdb_req !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no req expected=req", nm);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [RS-1:0] tag, input logic [31:0] exp,
                        input int off, input int hold);
    exp_t e;
    @(negedge clk);
    drive(op, a, b, tag);
    e.tag = tag;
    e.data = exp;
    e.e0 = cyc + 1;
    e.off = off;
    sb.push_back(e);
    @(negedge clk);
    bus.i_alu_ex_en = 1'b0;
    wait_req(nm);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(bus.o_cdb_req), 32'd1);
      chk("hold_data", bus.o_cdb_data, exp);
      chk("hold_tag", 32'(bus.o_cdb_rob_addr), 32'(tag));
    end
    bus.i_cdb_gnt = 1'b1;
    @(negedge clk);
    bus.i_cdb_gnt = 1'b0;
    chk("busy_after_gnt", 32'(bus.o_alu_busy), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_alu_ex_en = 1'b0;
    bus.i_alu_opcode = 3'd0;
    bus.i_rs1_value = 32'h0;
    bus.i_rs2_value = 32'h0;
    bus.i_rob_addr = '0;
    bus.i_cdb_gnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.o_alu_busy), 32'd0);
    chk("rst_req", 32'(bus.o_cdb_req), 32'd0);
    chk("rst_data", bus.o_cdb_data, 32'h0);
    chk("rst_tag", 32'(bus.o_cdb_rob_addr), 32'h0);
    rstn = 1'b1;

    // stray grant while idle must be ignored
    @(negedge clk);
    bus.i_cdb_gnt = 1'b1;
    @(negedge clk);
    bus.i_cdb_gnt = 1'b0;
    chk("idle_gnt_busy", 32'(bus.o_alu_busy), 32'd0);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 8'd3, 32'hFFFF_FFEB, MLAT, 0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 8'd4, 32'h4000_0000, MLAT, 0);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 8'd5, 32'h4000_0000, MLAT, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd6, 32'hFFFF_FFFF, MLAT, 0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd7, 32'hFFFF_FFFE, MLAT, 0);
    run_op("mul_neg", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd8, 32'h0000_0001, MLAT, 0);
    run_op("mulh_mix", 3'd1, 32'hFFFF_FFFF, 32'd5, 8'd9, 32'hFFFF_FFFF, MLAT, 0);

    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 8'd10, 32'hFFFF_FFFD, 32, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 8'd11, 32'hFFFF_FFFF, 32, 0);
    run_op("divu_z", 3'd5, 32'd100, 32'd0, 8'd12, 32'hFFFF_FFFF, 0, 0);
    run_op("remu_z", 3'd7, 32'd100, 32'd0, 8'd13, 32'd100, 0, 0);
    run_op("div_z", 3'd4, 32'hFFFF_FFFB, 32'd0, 8'd14, 32'hFFFF_FFFF, 0, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 8'd15, 32'd14, 32, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 8'd16, 32'd2, 32, 0);
    run_op("divu_big", 3'd5, 32'hFFFF_FFFF, 32'd1, 8'd17, 32'hFFFF_FFFF, 32, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 8'd18, 32'h8000_0000, 0, 3);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 8'd19, 32'h0, 0, 0);

    // flush ten cycles into a divide: no broadcast
    @(negedge clk);
    drive(3'd4, 32'hFFFF_FFF9, 32'd2, 8'd20);
    @(negedge clk);
    bus.i_alu_ex_en = 1'b0;
    repeat (9) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_busy", 32'(bus.o_alu_busy), 32'd0);
    chk("flush_req", 32'(bus.o_cdb_req), 32'd0);

    // flush coincident with dispatch: not accepted
    drive(3'd5, 32'd100, 32'd0, 8'd21);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_alu_ex_en = 1'b0;
    chk("flush_en_busy", 32'(bus.o_alu_busy), 32'd0);
    @(negedge clk);
    chk("flush_en_req", 32'(bus.o_cdb_req), 32'd0);

    run_op("divu_9_2", 3'd5, 32'd9, 32'd2, 8'd22, 32'd4, 32, 0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    drive(3'd0, 32'd3, 32'd5, 8'd23);
    @(negedge clk);
    bus.i_alu_ex_en = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.o_alu_busy), 32'd0);
    chk("arst_req", 32'(bus.o_cdb_req), 32'd0);
    chk("arst_data", bus.o_cdb_data, 32'h0);
    chk("arst_tag", 32'(bus.o_cdb_rob_addr), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // dispatch strobe held for three cycles: one acceptance only
    begin
      exp_t e;
      @(negedge clk);
      drive(3'd5, 32'd100, 32'd0, 8'd24);
      e.tag = 8'd24;
      e.data = 32'hFFFF_FFFF;
      e.e0 = cyc + 1;
      e.off = 0;
      sb.push_back(e);
      repeat (3) @(negedge clk);
      bus.i_alu_ex_en = 1'b0;
      wait_req("held_en");
      bus.i_cdb_gnt = 1'b1;
      @(negedge clk);
      bus.i_cdb_gnt = 1'b0;
      chk("held_en_busy", 32'(bus.o_alu_busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("held_en_req", 32'(bus.o_cdb_req), 32'd0);
    end

    run_op("post_rst_mul", 3'd0, 32'd3, 32'd5, 8'd25, 32'd15, MLAT, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
